alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's single-register ALU. Accepts one operation per cycle over a valid/ready input channel and returns a registered result with condition flags and a passthrough tag over a valid/ready output channel. An optional iterative shift-add multiplier adds a multi-cycle opcode. Sits between the decode stage and write-back in the RISC datapath.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/shift_add_mul.sv | 52 +++++
 rtl/alu_pipe.sv | 195 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by alu_pipe.
// mk_flags packs {V,C,N,Z} using the FLAG_* indices.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLA = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] mk_flags(
        input logic v,
        input logic c,
        input logic n,
        input logic z
    );
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative unsigned multiplier, one partial product per cycle.
// Ports: clk, rst (sync high), start, a, b -> done (final-iteration strobe), product.
module shift_add_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] addend;

    // product is the value acc takes at the coming edge, so on the
    // last iteration it already holds the complete result.
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result, {V,C,N,Z} flags, err and tag.
// Ports: in_valid/in_ready/op/in1/in2/in_tag in, out_valid/out_ready/out/flags/err/out_tag out.
// Define ALU_MUL_EN to add the multi-cycle MUL opcode (shift_add_mul).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH_W = $clog2(WIDTH);

    state_t state;
    state_t state_nx;

    logic             accept;
    logic             is_mul;
    logic             ld_alu;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;
    logic [TAG_W-1:0] mul_tag;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             res_e;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   shr;
    logic [WIDTH:0]   sha;
    logic [SH_W-1:0]  sh;
    logic             big;

`ifdef ALU_MUL_EN
    assign is_mul = (op == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif

    assign accept = in_valid && in_ready;
    assign ld_alu = accept && !is_mul;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
`ifdef ALU_MUL_EN
        unique case (state)
            ST_IDLE: if (accept && is_mul) state_nx = ST_BUSY;
            ST_BUSY: if (mul_done)         state_nx = ST_DONE;
            ST_DONE: if (out_ready)        state_nx = ST_IDLE;
            default:                       state_nx = ST_IDLE;
        endcase
`else
        state_nx = ST_IDLE;
`endif
    end

    always_comb begin
        in_ready = 1'b0;
        if (!rst && state == ST_IDLE)
            in_ready = !out_valid || out_ready;
    end

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_start = accept && is_mul;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in1),
        .b       (in2),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign mul_lo    = mul_prod[WIDTH-1:0];
    assign mul_hi_nz = |mul_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst)            mul_tag <= '0;
        else if (mul_start) mul_tag <= in_tag;
    end
`else
    assign mul_done  = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi_nz = 1'b0;
    assign mul_tag   = '0;
`endif

    // Extra bit on each shift catches the last bit shifted out.
    assign sh  = in2[SH_W-1:0];
    assign big = |in2[WIDTH-1:SH_W];
    assign sum = {1'b0, in1} + {1'b0, in2};
    assign dif = {1'b0, in1} - {1'b0, in2};
    assign shl = {1'b0, in1} << sh;
    assign shr = {in1, 1'b0} >> sh;
    assign sha = $signed({in1, 1'b0}) >>> sh;

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        res_e = 1'b0;
        unique case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                        (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                res   = dif[WIDTH-1:0];
                res_c = dif[WIDTH];
                res_v = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                        (dif[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND: res = in1 & in2;
            OP_OR:  res = in1 | in2;
            OP_XOR: res = in1 ^ in2;
            OP_NOT: res = ~in1;
            OP_SLA: begin
                if (!big) begin
                    res   = shl[WIDTH-1:0];
                    res_c = shl[WIDTH];
                end
            end
            OP_SRA: begin
                if (big) begin
                    res = {WIDTH{in1[WIDTH-1]}};
                end else begin
                    res   = sha[WIDTH:1];
                    res_c = sha[0];
                end
            end
            OP_SRL: begin
                if (!big) begin
                    res   = shr[WIDTH:1];
                    res_c = shr[0];
                end
            end
            default: res_e = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
            err       <= 1'b0;
            out_tag   <= '0;
        end else if (ld_alu) begin
            out_valid <= 1'b1;
            out       <= res;
            flags     <= mk_flags(res_v, res_c, res[WIDTH-1], res == '0);
            err       <= res_e;
            out_tag   <= in_tag;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            out       <= mul_lo;
            flags     <= mk_flags(1'b0, mul_hi_nz, mul_lo[WIDTH-1],
                                  mul_lo == '0);
            err       <= 1'b0;
            out_tag   <= mul_tag;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against an arithmetic model.
// Works with or without ALU_MUL_EN defined.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic [3:0]  flags;
    logic        err;
    logic [3:0]  out_tag;

    int n_assert = 0;
    int n_fail   = 0;

    // {tag, err, flags, out}
    logic [40:0] q[$];

    alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .err       (err),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // Returns {err, V, C, N, Z, out} from the operation's arithmetic meaning.
    function automatic logic [36:0] model(input logic [3:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        c, v, e;
        logic [63:0] w;
        longint      sa, sb, sr;
        r = '0; c = 0; v = 0; e = 0;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            4'd0: begin
                w  = {32'd0, a} + {32'd0, b};
                r  = w[31:0];
                c  = w[32];
                sr = sa + sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                r  = a - b;
                c  = a < b;
                sr = sa - sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin
                if (b < 32) begin
                    r = a << b;
                    c = (b != 0) ? a[32 - b] : 1'b0;
                end
            end
            4'd7: begin
                if (b >= 32) r = a[31] ? 32'hFFFF_FFFF : 32'h0;
                else begin
                    r = $signed(a) >>> b;
                    c = (b != 0) ? a[b - 1] : 1'b0;
                end
            end
            4'd8: begin
                if (b < 32) begin
                    r = a >> b;
                    c = (b != 0) ? a[b - 1] : 1'b0;
                end
            end
`ifdef ALU_MUL_EN
            4'd9: begin
                w = {32'd0, a} * {32'd0, b};
                r = w[31:0];
                c = (w[63:32] != 0);
            end
`endif
            default: e = 1;
        endcase
        return {e, v, c, r[31], (r == 0), r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        #1;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        chk({nm, "_acc"}, 64'(k < 100), 64'd1);
    endtask

    task automatic do_op(input string nm, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input logic [31:0] e_out,
                         input logic [3:0] e_fl, input logic e_err);
        out_ready = 1; in_valid = 1;
        op = o; in1 = a; in2 = b; in_tag = t;
        wait_ready(nm);
        tick();
        in_valid = 0;
        chk({nm, "_vld"}, 64'(out_valid), 64'd1);
        chk({nm, "_out"}, 64'(out), 64'(e_out));
        chk({nm, "_flg"}, 64'(flags), 64'(e_fl));
        chk({nm, "_err"}, 64'(err), 64'(e_err));
        chk({nm, "_tag"}, 64'(out_tag), 64'(t));
        tick();
        chk({nm, "_ret"}, 64'(out_valid), 64'd0);
    endtask

    // One cycle of the streaming scoreboard.
    task automatic step(input bit v, input bit r, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t);
        bit          e_rdy;
        logic [36:0] m;
        logic [40:0] f;
        in_valid = v; op = o; in1 = a; in2 = b; in_tag = t; out_ready = r;
        #1;
        e_rdy = (q.size() == 0) || r;
        chk("s_rdy", 64'(in_ready), 64'(e_rdy));
        chk("s_vld", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            f = q[0];
            chk("s_out", 64'(out), 64'(f[31:0]));
            chk("s_flg", 64'(flags), 64'(f[35:32]));
            chk("s_err", 64'(err), 64'(f[36]));
            chk("s_tag", 64'(out_tag), 64'(f[40:37]));
            if (r) void'(q.pop_front());
        end
        if (v && e_rdy) begin
            m = model(o, a, b);
            q.push_back({t, m});
        end
        tick();
    endtask

`ifdef ALU_MUL_EN
    task automatic do_mul(input string nm, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
        int          cyc;
        logic [36:0] m;
        m = model(4'd9, a, b);
        out_ready = 1; in_valid = 1;
        op = 4'd9; in1 = a; in2 = b; in_tag = t;
        wait_ready(nm);
        tick();
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            chk({nm, "_busy_rdy"}, 64'(in_ready), 64'd0);
            tick();
            cyc++;
        end
        chk({nm, "_lat"}, 64'(cyc), 64'd32);
        chk({nm, "_out"}, 64'(out), 64'(m[31:0]));
        chk({nm, "_flg"}, 64'(flags), 64'(m[35:32]));
        chk({nm, "_err"}, 64'(err), 64'd0);
        chk({nm, "_tag"}, 64'(out_tag), 64'(t));
        tick();
        chk({nm, "_ret"}, 64'(out_valid), 64'd0);
    endtask
`endif

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        logic [31:0] hold;
        int          seen;

        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_flg", 64'(flags), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        rst = 0;

        do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 4'd3,
              32'h0, 4'b0101, 1'b0);
        do_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h1, 4'd5,
              32'h7FFF_FFFF, 4'b1000, 1'b0);
        do_op("sub_brw", 4'd1, 32'h1, 32'h2, 4'd6,
              32'hFFFF_FFFF, 4'b0110, 1'b0);
        do_op("sra_4", 4'd7, 32'h8000_0010, 32'd4, 4'd7,
              32'hF800_0001, 4'b0010, 1'b0);
        do_op("sra_40", 4'd7, 32'h8000_0010, 32'd40, 4'd8,
              32'hFFFF_FFFF, 4'b0010, 1'b0);
        do_op("sla_31", 4'd6, 32'h1, 32'd31, 4'd9,
              32'h8000_0000, 4'b0010, 1'b0);
        do_op("srl_c", 4'd8, 32'h0000_0003, 32'd1, 4'd2,
              32'h1, 4'b0100, 1'b0);
        do_op("sla_32", 4'd6, 32'hFFFF_FFFF, 32'd32, 4'd1,
              32'h0, 4'b0001, 1'b0);
        do_op("ill_f", 4'hF, 32'h1234, 32'h5678, 4'd10,
              32'h0, 4'b0001, 1'b1);
`ifndef ALU_MUL_EN
        do_op("ill_9", 4'd9, 32'h10000, 32'h10000, 4'd11,
              32'h0, 4'b0001, 1'b1);
`endif

        // back-to-back ADDs, one result per cycle
        for (int i = 0; i < 8; i++)
            step(1, 1, 4'd0, $urandom, $urandom, 4'(i));
        step(0, 1, 4'd0, 0, 0, 0);
        chk("b2b_drain", 64'(q.size()), 64'd0);

        // stall mid-stream: output must hold, input must block
        step(1, 1, 4'd2, 32'hF0F0_1234, 32'hFF00_FF00, 4'd4);
        hold = out;
        step(1, 0, 4'd4, 32'hAAAA_5555, 32'h0F0F_0F0F, 4'd12);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 4'd3, 32'h1, 32'h2, 4'd13);
            chk("stall_hold", 64'(out), 64'(hold));
        end
        step(1, 1, 4'd3, 32'h1, 32'h2, 4'd13);
        step(0, 1, 4'd0, 0, 0, 0);
        step(0, 1, 4'd0, 0, 0, 0);
        chk("stall_drain", 64'(q.size()), 64'd0);

        // random stream with random backpressure
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
            if (ro == 4'd9) ro = 4'd0;
`endif
            ra = $urandom;
            rb = $urandom;
            if (ro >= 4'd6 && ro <= 4'd8 && $urandom_range(0, 3) != 0)
                rb = 32'($urandom_range(0, 40));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                 ro, ra, rb, 4'($urandom));
        end
        for (int i = 0; i < 3; i++) step(0, 1, 4'd0, 0, 0, 0);
        chk("rand_drain", 64'(q.size()), 64'd0);

`ifdef ALU_MUL_EN
        do_mul("mul_16", 32'h10000, 32'h10000, 4'd14);
        do_mul("mul_r1", $urandom, $urandom, 4'd1);
        do_mul("mul_r2", 32'($urandom_range(0, 65535)), 32'd3, 4'd2);

        // reset in the middle of a multiplication drops it
        out_ready = 1; in_valid = 1;
        op = 4'd9; in1 = 32'h10000; in2 = 32'h10000; in_tag = 4'd15;
        wait_ready("mul_rst");
        tick();
        in_valid = 0;
        repeat (9) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mul_rst_vld", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("mul_rst_none", 64'(seen), 64'd0);
        chk("mul_rst_rdy", 64'(in_ready), 64'd1);
        do_op("post_rst", 4'd0, 32'd2, 32'd3, 4'd6, 32'd5, 4'b0000, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
